// File: rtl/macro_arbiter_rr_onehot_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the grant consumer.
// master: arbiter side; slave: requester/consumer side.
interface macro_arbiter_rr_onehot_if #(
    parameter int unsigned SEL_WIDTH = 2
);
    localparam int unsigned N = 1 << SEL_WIDTH;

    logic [N-1:0] req;
    logic [N-1:0] grant_onehot;
    logic         grant_valid;
    logic         grant_ready;

    modport master (
        input  req,
        input  grant_ready,
        output grant_onehot,
        output grant_valid
    );

    modport slave (
        output req,
        output grant_ready,
        input  grant_onehot,
        input  grant_valid
    );
endinterface

// File: rtl/macro_arbiter_rr_onehot.sv
// Registered round-robin arbiter producing a one-hot grant with valid/ready handshake.
// Define MACRO_ARBITER_RR_FIXED_PRIORITY_EN for fixed priority (index 0 highest).
module macro_arbiter_rr_onehot #(
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    macro_arbiter_rr_onehot_if.master   bus
);
    localparam int unsigned N = 1 << SEL_WIDTH;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] grant;
    logic [N-1:0] grant_next;
    logic [N-1:0] ptr;
    logic [N-1:0] ptr_next;
    logic [N-1:0] ptr_rot;
    logic [N-1:0] win_idle;
    logic [N-1:0] win_hs;

    // Lowest set request at or above the one-hot pointer, else lowest set request overall.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
        logic [N-1:0] masked;
        logic [N-1:0] src;
        masked = r & ~(p - ONE);
        src    = (masked != '0) ? masked : r;
        return src & (~src + ONE);
    endfunction

`ifdef MACRO_ARBITER_RR_FIXED_PRIORITY_EN
    always_comb ptr_rot = ONE;
`else
    always_comb ptr_rot = {grant[N-2:0], grant[N-1]};
`endif

    always_comb begin
        win_idle = pick(bus.req, ptr);
        win_hs   = pick(bus.req, ptr_rot);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= ONE;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state logic; ptr moves only on an accepted grant
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    grant_next = win_idle;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (bus.grant_ready) begin
                    ptr_next   = ptr_rot;
                    grant_next = win_hs;
                    state_next = (win_hs != '0) ? GRANT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.grant_valid  = (state == GRANT);
        bus.grant_onehot = grant;
    end
endmodule
